// File: rtl/div_pkg.sv
// Shared types and constants for the divide sequencer that feeds the
// iterative divider and commits results to HI/LO.
package div_pkg;

  localparam int DIV_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } div_state_t;

  localparam logic [3:0] CTRL_IDLE  = 4'b0000;
  localparam logic [3:0] CTRL_START = 4'b0001;
  localparam logic [3:0] CTRL_RUN   = 4'b0010;

  // LO value written on a divide-by-zero
  localparam logic [DIV_WIDTH-1:0] DZ_LO = 16'hFFFF;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate for a pair of values; gives operand
// magnitudes on the request side and signed results on the commit side.
module div_sign_fix #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_in,
  input  logic             a_neg,
  input  logic [WIDTH-1:0] b_in,
  input  logic             b_neg,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out
);

  assign a_out = a_neg ? -a_in : a_in;
  assign b_out = b_neg ? -b_in : b_in;

endmodule

// File: rtl/div_hilo_ctrl.sv
// HI/LO divide sequencer with mfhi/mflo/mthi/mtlo interlock.
// Optional WAIT watchdog enabled by defining DIV_HILO_TIMEOUT_EN.
module div_hilo_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH   = DIV_WIDTH,
  parameter int TIMEOUT = 40
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_signed,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
  output logic [3:0]         div_ctrl,
  output logic [WIDTH-1:0]   div_dividend,
  output logic [WIDTH-1:0]   div_divisor,
  input  logic               div_validity,
  input  logic [2*WIDTH-1:0] div_result,
  input  logic               mt_hi_we,
  input  logic               mt_lo_we,
  input  logic [WIDTH-1:0]   mt_data,
  input  logic               mf_req,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               busy,
  output logic               stall,
  output logic               dz_pulse,
  output logic               to_pulse
);

  div_state_t       state_q, state_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             quo_neg_q, quo_neg_d, rem_neg_q, rem_neg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] a_mag, b_mag, quo_fix, rem_fix;
`ifdef DIV_HILO_TIMEOUT_EN
  logic [5:0]       cnt_q, cnt_d;
  logic             to_q, to_d;
`endif

  div_sign_fix #(.WIDTH(WIDTH)) u_operand_fix (
    .a_in  (req_a),
    .a_neg (req_signed & req_a[WIDTH-1]),
    .b_in  (req_b),
    .b_neg (req_signed & req_b[WIDTH-1]),
    .a_out (a_mag),
    .b_out (b_mag)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_result_fix (
    .a_in  (div_result[2*WIDTH-1:WIDTH]),
    .a_neg (quo_neg_q),
    .b_in  (div_result[WIDTH-1:0]),
    .b_neg (rem_neg_q),
    .a_out (quo_fix),
    .b_out (rem_fix)
  );

  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    dz_d      = 1'b0;
`ifdef DIV_HILO_TIMEOUT_EN
    cnt_d     = cnt_q;
    to_d      = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (mt_hi_we) hi_d = mt_data;
        if (mt_lo_we) lo_d = mt_data;
        if (req_valid) begin
          dvd_d     = a_mag;
          dvs_d     = b_mag;
          quo_neg_d = req_signed & (req_a[WIDTH-1] ^ req_b[WIDTH-1]);
          rem_neg_d = req_signed & req_a[WIDTH-1];
          // Divide-by-zero commits immediately and overrides any mt write
          if (req_b == '0) begin
            hi_d = req_a;
            lo_d = DZ_LO;
            dz_d = 1'b1;
          end else begin
            state_d = ST_LAUNCH;
            ctrl_d  = CTRL_START;
          end
        end
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT;
        ctrl_d  = CTRL_RUN;
`ifdef DIV_HILO_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ST_WAIT: begin
        if (div_validity) begin
          lo_d    = quo_fix;
          hi_d    = rem_fix;
          state_d = ST_IDLE;
          ctrl_d  = CTRL_IDLE;
        end
`ifdef DIV_HILO_TIMEOUT_EN
        else if (cnt_q == 6'(TIMEOUT - 1)) begin
          state_d = ST_IDLE;
          ctrl_d  = CTRL_IDLE;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
        ctrl_d  = CTRL_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ctrl_q    <= CTRL_IDLE;
      dvd_q     <= '0;
      dvs_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
`ifdef DIV_HILO_TIMEOUT_EN
      cnt_q     <= '0;
      to_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      dz_q      <= dz_d;
`ifdef DIV_HILO_TIMEOUT_EN
      cnt_q     <= cnt_d;
      to_q      <= to_d;
`endif
    end
  end

  assign req_ready    = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign stall        = busy & (mf_req | mt_hi_we | mt_lo_we | req_valid);
  assign div_ctrl     = ctrl_q;
  assign div_dividend = dvd_q;
  assign div_divisor  = dvs_q;
  assign hi           = hi_q;
  assign lo           = lo_q;
  assign dz_pulse     = dz_q;
`ifdef DIV_HILO_TIMEOUT_EN
  assign to_pulse     = to_q;
`else
  assign to_pulse     = 1'b0;
`endif

endmodule

// File: doc/div_hilo_ctrl.md
# div_hilo_ctrl

Sequencer that sits directly upstream and downstream of the 16-bit iterative divider. It accepts divide requests from the decode/execute stage and converts signed operands to magnitudes. It then drives the divider's control code and waits for its validity, sign-corrects the `{quotient, remainder}` result, and commits it to the HI/LO register pair. It also provides the pipeline interlock for `mfhi`/`mflo`/`mthi`/`mtlo` while a divide is in flight.

## Interface
- `WIDTH`, 16, operand/HI/LO width; fixed to the divider width.
- `TIMEOUT`, 40, maximum WAIT cycles before abort (used only with `DIV_HILO_TIMEOUT_EN`).

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req_valid`  in  1  divide request.
- `req_ready`  out  1  high in IDLE only.
- `req_signed`  in  1  1 = `div`, 0 = `divu`.
- `req_a`  in  WIDTH  dividend.
- `req_b`  in  WIDTH  divisor.
- `div_ctrl`  out  4  divider control: `4'b0000` IDLE, `4'b0001` START, `4'b0010` RUN.
- `div_dividend`  out  WIDTH  magnitude of the dividend, held from LAUNCH through WAIT.
- `div_divisor`  out  WIDTH  magnitude of the divisor, held from LAUNCH through WAIT.
- `div_validity`  in  1  divider done, level.
- `div_result`  in  2*WIDTH  `{quotient, remainder}` magnitudes.
- `mt_hi_we`  in  1  `mthi` write strobe.
- `mt_lo_we`  in  1  `mtlo` write strobe.
- `mt_data`  in  WIDTH  write data for `mthi`/`mtlo`.
- `mf_req`  in  1  `mfhi`/`mflo` in execute.
- `hi`  out  WIDTH  HI register (remainder); reset 0.
- `lo`  out  WIDTH  LO register (quotient); reset 0.
- `busy`  out  1  high in LAUNCH and WAIT.
- `stall`  out  1  `busy & (mf_req | mt_hi_we | mt_lo_we | req_valid)`.
- `dz_pulse`  out  1  one-cycle divide-by-zero indication.
- `to_pulse`  out  1  one-cycle timeout indication; tied 0 without the macro.

## Operation
- FSM states: IDLE, LAUNCH, WAIT.
- **Reset:** state IDLE; `hi`/`lo` 0; `div_ctrl` IDLE; operand registers 0; all pulses 0.
- **IDLE:** a handshake (`req_valid & req_ready`) registers the operand magnitudes and the sign bits.
  - Sign bits: `neg_q = req_signed & (a[15] ^ b[15])` and `neg_r = req_signed & a[15]`.
  - Magnitudes: two's-complement absolute value when `req_signed` is 1, otherwise raw. `abs(16'h8000) = 16'h8000` taken as unsigned.
  - If `req_b == 0`: no launch; on that edge `hi <= req_a` (raw), `lo <= 16'hFFFF`, `dz_pulse` high next cycle, state stays IDLE.
- **LAUNCH:** lasts exactly one cycle with `div_ctrl = START`, then WAIT.
- **WAIT:** `div_ctrl = RUN`, operands held.
  - On the first edge with `div_validity` = 1, apply sign correction: `lo <= neg_q ? -q : q` and `hi <= neg_r ? -r : r`.
  - Then go to IDLE.
  - `div_validity` is ignored outside WAIT.
- **Overflow:** `-32768 / -1` gives `lo = 16'h8000`, `hi = 0`, with no flag.
- **mthi/mtlo:** honoured only when not busy. Same-cycle `mthi` plus request acceptance: the `mt` write lands and is later overwritten by the divide result. A divide-by-zero commit on the same edge has priority over `mt` writes.
- **Reset mid-operation:** returns to IDLE immediately and clears HI/LO. The divider keeps no state across a new START.

## Timing
- Request accepted at edge 0; LAUNCH in cycle 1; WAIT from cycle 2.
- Result is committed on the edge where WAIT samples `div_validity`. `busy` drops and `req_ready` rises in the following cycle.
- Total latency is `divider latency + 2` cycles. Divide-by-zero latency is 1 cycle.
- `hi`/`lo` are registered outputs; `stall`, `req_ready` and `busy` are decoded from the state only (no comb path from `div_validity`).

## Configuration
- `DIV_HILO_TIMEOUT_EN` defined:
  - A 6-bit counter clears on entering WAIT.
  - If it reaches `TIMEOUT-1` without `div_validity`: state becomes IDLE, HI/LO are unchanged, `div_ctrl` becomes IDLE, and `to_pulse` is high for 1 cycle.
- Undefined: the counter is absent, WAIT waits indefinitely, and `to_pulse` is 0.

## Structure
- Package `div_pkg`: FSM state enum, the `div_ctrl` code constants (IDLE/START/RUN), `WIDTH` default, and the divide-by-zero LO constant.
- One sub-module, `div_sign_fix`: combinational magnitude/negate for the operand and result paths, instantiated twice.

## Test plan
- `divu 100/7` -> `div_ctrl` START for exactly 1 cycle; after validity, `lo = 14`, `hi = 2`; `busy` low the next cycle.
- `div -100/7` -> divider sees 100 and 7; `lo = 16'hFFF2` (-14), `hi = 16'hFFFE` (-2).
- `div 5/0` -> no START issued; `hi = 5`, `lo = 16'hFFFF`, `dz_pulse` for 1 cycle; `req_ready` stays high.
- `mf_req` and `mt_hi_we` during WAIT -> `stall` = 1 and `hi` untouched; once `stall` drops, `mthi 16'h1234` writes `hi = 16'h1234`.
- `rst_n` low in WAIT -> async return to IDLE with `hi = lo = 0`; a new `divu 9/3` gives `lo = 3`, `hi = 0`.
- With `DIV_HILO_TIMEOUT_EN`, hold `div_validity` at 0 -> after 40 WAIT cycles, `to_pulse` high for 1 cycle and HI/LO keep their prior values.
